// File: rtl/score_glyph_reader_pkg.sv
// Shared constants, font table and FSM state type for the score glyph reader.
// The testbench renderer draws digits from the same font table.
package score_glyph_reader_pkg;

    localparam int unsigned GRID_W     = 16;
    localparam int unsigned BMP_W      = 769;
    localparam int unsigned NDIG       = 3;
    localparam int unsigned GLYPH_ROWS = 5;
    localparam int unsigned GLYPH_COLS = 3;
    localparam int unsigned GLYPH_BITS = GLYPH_ROWS * GLYPH_COLS;
    localparam int unsigned NFONT      = 10;
    localparam int unsigned STEP_W     = 10;
    localparam int unsigned IDX_W      = 11;
    localparam int unsigned DIGIT_W    = 10;

    localparam logic [DIGIT_W-1:0] NOMATCH = 10'd15;

    // Pixel (r,c) lives at glyph bit 14-3r-c, so each literal reads row0..row4, col0..col2.
    localparam logic [NFONT-1:0][GLYPH_BITS-1:0] FONT_TABLE = {
        15'b111_101_111_001_111,   // 9
        15'b111_101_111_101_111,   // 8
        15'b111_001_001_001_001,   // 7
        15'b111_100_111_101_111,   // 6
        15'b111_100_111_001_111,   // 5
        15'b101_101_111_001_001,   // 4
        15'b111_001_111_001_111,   // 3
        15'b111_001_111_100_111,   // 2
        15'b001_001_001_001_001,   // 1
        15'b111_101_101_101_111    // 0
    };

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        MATCH = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Bits past the end of the bitmap read as zero (shift beyond width yields 0).
    function automatic logic pixel_at(input logic [BMP_W-1:0] bm, input logic [IDX_W-1:0] idx);
        logic [BMP_W-1:0] sh;
        sh = bm >> idx;
        return sh[0];
    endfunction

    function automatic logic [DIGIT_W-1:0] digit_out(input logic hit, input logic [3:0] d);
        return hit ? DIGIT_W'(d) : NOMATCH;
    endfunction

endpackage

// File: rtl/score_glyph_reader_match.sv
// Exact 15-pixel compare of a glyph against the font table.
module glyph_match
    import score_glyph_reader_pkg::*;
(
    input  logic [GLYPH_BITS-1:0] glyph,
    output logic [3:0]            digit,
    output logic                  hit
);

    always_comb begin
        digit = '0;
        hit   = 1'b0;
        for (int unsigned d = 0; d < NFONT; d++) begin
            if (glyph == FONT_TABLE[4'(d)]) begin
                digit = 4'(d);
                hit   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/score_glyph_reader.sv
// Reads three 3x5 digit glyphs out of a snapshotted score bitmap, one row per cycle,
// and publishes the decoded digits together with a one-cycle done pulse.
module score_glyph_reader
    import score_glyph_reader_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [BMP_W-1:0]     bitmap,
    input  logic [STEP_W-1:0]    step1,
    input  logic [STEP_W-1:0]    step2,
    input  logic [STEP_W-1:0]    step3,
    output logic [DIGIT_W-1:0]   digit1,
    output logic [DIGIT_W-1:0]   digit2,
    output logic [DIGIT_W-1:0]   digit3,
    output logic [NDIG-1:0]      valid,
    output logic                 busy,
    output logic                 done
);

    state_t                        state;
    logic [BMP_W-1:0]              bmp_q;
    logic [NDIG-1:0][STEP_W-1:0]   step_q;
    logic [1:0]                    k;
    logic [2:0]                    r;
    logic [GLYPH_BITS-1:0]         glyph_q;
    logic [NDIG-1:0][3:0]          res_digit;
    logic [NDIG-1:0]               res_hit;

    logic [1:0]                    kidx_c;
    logic [STEP_W-1:0]             cur_step_c;
    logic [IDX_W-1:0]              row_base_c;
    logic [GLYPH_COLS-1:0]         row_bits_c;
    logic [3:0]                    match_digit_c;
    logic                          match_hit_c;

    assign kidx_c     = k - 2'd1;
    assign cur_step_c = step_q[kidx_c];
    assign row_base_c = IDX_W'(cur_step_c) + IDX_W'(GRID_W * 32'(r));

    // Current row of the current glyph, col0 in the MSB; 11-bit indices never wrap.
    always_comb begin
        row_bits_c = '0;
        for (int unsigned c = 0; c < GLYPH_COLS; c++) begin
            row_bits_c[GLYPH_COLS-1-c] = pixel_at(bmp_q, row_base_c + IDX_W'(c));
        end
    end

    glyph_match u_match (
        .glyph (glyph_q),
        .digit (match_digit_c),
        .hit   (match_hit_c)
    );

    // Outputs are loaded on entry to DONE so they change together with the done pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            k         <= 2'd1;
            r         <= '0;
            glyph_q   <= '0;
            res_digit <= '0;
            res_hit   <= '0;
            digit1    <= '0;
            digit2    <= '0;
            digit3    <= '0;
            valid     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        bmp_q  <= bitmap;
                        step_q <= {step3, step2, step1};
                        k      <= 2'd1;
                        r      <= '0;
                        busy   <= 1'b1;
                        state  <= FETCH;
                    end
                end
                FETCH: begin
                    // Five shifts fully replace the glyph, so no clear between digits.
                    glyph_q <= {glyph_q[GLYPH_BITS-GLYPH_COLS-1:0], row_bits_c};
                    if (r == 3'(GLYPH_ROWS - 1)) begin
                        state <= MATCH;
                    end else begin
                        r <= r + 3'd1;
                    end
                end
                MATCH: begin
                    res_digit[kidx_c] <= match_digit_c;
                    res_hit[kidx_c]   <= match_hit_c;
                    if (k != 2'(NDIG)) begin
                        k     <= k + 2'd1;
                        r     <= '0;
                        state <= FETCH;
                    end else begin
                        digit1 <= digit_out(res_hit[0], res_digit[0]);
                        digit2 <= digit_out(res_hit[1], res_digit[1]);
                        digit3 <= digit_out(match_hit_c, match_digit_c);
                        valid  <= {match_hit_c, res_hit[1], res_hit[0]};
                        done   <= 1'b1;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
